// File: rtl/fmul_seq_ctrl.sv
// Sequential 8x8 multiplier controller covering the MUL/MULS/MULSU/FMUL/FMULS/FMULSU family.
// Multiplies unsigned magnitudes by shift-add over 8 cycles, then applies the sign and the fractional shift.
module fmul_seq_ctrl (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_start,
    input  logic [2:0] i_op,
    input  logic [7:0] i_rd,
    input  logic [7:0] i_rr,
    output logic       o_busy,
    output logic       o_done,
    output logic [7:0] o_r1,
    output logic [7:0] o_r0,
    output logic       o_c,
    output logic       o_z,
    output logic       o_err
);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t      state_q, state_d;
    logic [2:0]  count_q, count_d;
    logic [15:0] acc_q, acc_d;
    logic [7:0]  rd_mag_q, rd_mag_d;
    logic [7:0]  rr_mag_q, rr_mag_d;
    logic        neg_q, neg_d;
    logic        fop_q, fop_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic [15:0] r_q, r_d;
    logic        c_q, c_d;
    logic        z_q, z_d;

    logic        rd_signed, rr_signed, op_legal;
    logic [7:0]  rd_in_mag, rr_in_mag;
    logic [15:0] addend, prod, res;

    always_comb begin
        rd_signed = (i_op == 3'd1) || (i_op == 3'd2) || (i_op == 3'd4) || (i_op == 3'd5);
        rr_signed = (i_op == 3'd1) || (i_op == 3'd4);
        op_legal  = (i_op <= 3'd5);
        // Negating 0x80 wraps back to 0x80, which read unsigned is exactly magnitude 128.
        rd_in_mag = (rd_signed && i_rd[7]) ? (~i_rd + 8'd1) : i_rd;
        rr_in_mag = (rr_signed && i_rr[7]) ? (~i_rr + 8'd1) : i_rr;
        addend    = {8'd0, rd_mag_q} << count_q;
        prod      = neg_q ? (~acc_q + 16'd1) : acc_q;
        res       = fop_q ? {prod[14:0], 1'b0} : prod;
    end

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        rd_mag_d = rd_mag_q;
        rr_mag_d = rr_mag_q;
        neg_d    = neg_q;
        fop_d    = fop_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        err_d    = 1'b0;
        r_d      = r_q;
        c_d      = c_q;
        z_d      = z_q;
        case (state_q)
            IDLE: begin
                if (i_start) begin
                    if (op_legal) begin
                        rd_mag_d = rd_in_mag;
                        rr_mag_d = rr_in_mag;
                        neg_d    = (rd_signed && i_rd[7]) ^ (rr_signed && i_rr[7]);
                        fop_d    = (i_op >= 3'd3);
                        acc_d    = 16'd0;
                        count_d  = 3'd0;
                        busy_d   = 1'b1;
                        state_d  = CALC;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            CALC: begin
                if (rr_mag_q[count_q]) begin
                    acc_d = acc_q + addend;
                end
                if (count_q == 3'd7) begin
                    count_d = 3'd0;
                    state_d = FIX;
                end else begin
                    count_d = count_q + 3'd1;
                end
            end
            FIX: begin
                r_d     = res;
                c_d     = prod[15];
                z_d     = (res == 16'd0);
                done_d  = 1'b1;
                state_d = DONE;
            end
            DONE: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q  <= IDLE;
            count_q  <= 3'd0;
            acc_q    <= 16'd0;
            rd_mag_q <= 8'd0;
            rr_mag_q <= 8'd0;
            neg_q    <= 1'b0;
            fop_q    <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
            r_q      <= 16'd0;
            c_q      <= 1'b0;
            z_q      <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            rd_mag_q <= rd_mag_d;
            rr_mag_q <= rr_mag_d;
            neg_q    <= neg_d;
            fop_q    <= fop_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            err_q    <= err_d;
            r_q      <= r_d;
            c_q      <= c_d;
            z_q      <= z_d;
        end
    end

    assign o_busy = busy_q;
    assign o_done = done_q;
    assign o_err  = err_q;
    assign o_r1   = r_q[15:8];
    assign o_r0   = r_q[7:0];
    assign o_c    = c_q;
    assign o_z    = z_q;

endmodule

// File: tb/tb_fmul_seq_ctrl.sv
// Bench for fmul_seq_ctrl: directed corner products, randomized products against an
// integer-arithmetic model, start-while-busy, back-to-back, reset abort and illegal ops.
module tb_fmul_seq_ctrl;

    logic       i_clk;
    logic       i_rst;
    logic       i_start;
    logic [2:0] i_op;
    logic [7:0] i_rd;
    logic [7:0] i_rr;
    logic       o_busy;
    logic       o_done;
    logic [7:0] o_r1;
    logic [7:0] o_r0;
    logic       o_c;
    logic       o_z;
    logic       o_err;

    int passed = 0;
    int total  = 0;

    fmul_seq_ctrl dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_start(i_start),
        .i_op   (i_op),
        .i_rd   (i_rd),
        .i_rr   (i_rr),
        .o_busy (o_busy),
        .o_done (o_done),
        .o_r1   (o_r1),
        .o_r0   (o_r0),
        .o_c    (o_c),
        .o_z    (o_z),
        .o_err  (o_err)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: exact integer product of the operands as interpreted by the op, returns {c, R}.
    function automatic logic [16:0] model(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr);
        int a, b, p;
        logic [15:0] pp, r;
        a = int'(rd);
        b = int'(rr);
        if ((op == 3'd1 || op == 3'd2 || op == 3'd4 || op == 3'd5) && rd[7]) a = a - 256;
        if ((op == 3'd1 || op == 3'd4) && rr[7]) b = b - 256;
        p  = a * b;
        pp = p[15:0];
        r  = (op >= 3'd3) ? {pp[14:0], 1'b0} : pp;
        return {pp[15], r};
    endfunction

    // Issues one accepted request from idle and reports what the DUT showed.
    task automatic run_op(input logic [2:0] op, input logic [7:0] rd, input logic [7:0] rr,
                          output int lat, output logic [15:0] r, output logic c, output logic z,
                          output logic done_after, output logic busy_after);
        @(negedge i_clk);
        i_start = 1'b1; i_op = op; i_rd = rd; i_rr = rr;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        i_op = 3'($urandom_range(0, 7));
        i_rd = 8'($urandom);
        i_rr = 8'($urandom);
        lat = 0;
        while (o_done !== 1'b1 && lat < 20) begin
            @(negedge i_clk);
            lat++;
        end
        r = {o_r1, o_r0};
        c = o_c;
        z = o_z;
        @(negedge i_clk);
        done_after = o_done;
        busy_after = o_busy;
    endtask

    task automatic test_reset();
        i_rst = 1'b0; i_start = 1'b0; i_op = 3'd0; i_rd = 8'd0; i_rr = 8'd0;
        #1 i_rst = 1'b1;
        #1;
        total++;
        if ({o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z} !== 21'd0) begin
            $display("FAIL reset_outputs: got busy=%b done=%b err=%b r=%h%h c=%b z=%b, want all zero",
                     o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z);
        end else passed++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        @(negedge i_clk);
        total++;
        if ({o_busy, o_done, o_err} !== 3'b000) begin
            $display("FAIL reset_idle: got busy=%b done=%b err=%b, want 000", o_busy, o_done, o_err);
        end else passed++;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd3, 3'd3, 3'd0, 3'd1, 3'd5, 3'd4};
        logic [7:0]  rds [6] = '{8'h80, 8'h80, 8'hFF, 8'h40, 8'hC0, 8'h80};
        logic [7:0]  rrs [6] = '{8'h80, 8'h00, 8'hFF, 8'hC0, 8'h40, 8'h80};
        logic [15:0] exr [6] = '{16'h8000, 16'h0000, 16'hFE01, 16'hF000, 16'hE000, 16'h8000};
        logic        exc [6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        logic        exz [6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        int lat;
        logic [15:0] r;
        logic c, z, da, ba;
        for (int i = 0; i < 6; i++) begin
            run_op(ops[i], rds[i], rrs[i], lat, r, c, z, da, ba);
            total++;
            if (lat !== 9) $display("FAIL dir_latency[%0d]: got %0d clocks, want 9", i, lat);
            else passed++;
            total++;
            if ({c, z, r} !== {exc[i], exz[i], exr[i]})
                $display("FAIL dir_result[%0d]: got r=%h c=%b z=%b, want r=%h c=%b z=%b",
                         i, r, c, z, exr[i], exc[i], exz[i]);
            else passed++;
            total++;
            if ({da, ba} !== 2'b00) $display("FAIL dir_single_pulse[%0d]: got done=%b busy=%b after pulse, want 00", i, da, ba);
            else passed++;
        end
        repeat (3) @(negedge i_clk);
        total++;
        if ({o_r1, o_r0, o_c, o_z} !== {exr[5], exc[5], exz[5]})
            $display("FAIL dir_hold: got r=%h%h c=%b z=%b, want r=%h c=%b z=%b", o_r1, o_r0, o_c, o_z, exr[5], exc[5], exz[5]);
        else passed++;
    endtask

    task automatic test_random();
        int lat;
        logic [15:0] r;
        logic c, z, da, ba;
        logic [2:0] op;
        logic [7:0] rd, rr;
        logic [16:0] exp;
        for (int i = 0; i < 30; i++) begin
            op = 3'($urandom_range(0, 5));
            rd = (i % 5 == 0) ? 8'h80 : 8'($urandom);
            rr = (i % 7 == 0) ? 8'h80 : (i % 11 == 0) ? 8'h00 : 8'($urandom);
            exp = model(op, rd, rr);
            run_op(op, rd, rr, lat, r, c, z, da, ba);
            total++;
            if ({lat == 9, c, z, r} !== {1'b1, exp[16], exp[15:0] == 16'd0, exp[15:0]})
                $display("FAIL rand[%0d] op=%0d rd=%h rr=%h: got lat=%0d r=%h c=%b z=%b, want lat=9 r=%h c=%b z=%b",
                         i, op, rd, rr, lat, r, c, z, exp[15:0], exp[16], exp[15:0] == 16'd0);
            else passed++;
        end
    endtask

    task automatic test_ignore_start();
        int pulses = 0;
        logic [15:0] r = 16'd0;
        logic [16:0] exp = model(3'd0, 8'h12, 8'h34);
        @(negedge i_clk);
        i_start = 1'b1; i_op = 3'd0; i_rd = 8'h12; i_rr = 8'h34;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(negedge i_clk);
        i_start = 1'b1; i_op = 3'd4; i_rd = 8'h80; i_rr = 8'h7F;
        @(negedge i_clk);
        i_start = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin
                pulses++;
                r = {o_r1, o_r0};
            end
        end
        total++;
        if (pulses !== 1) $display("FAIL ignore_pulses: got %0d done pulses, want 1", pulses);
        else passed++;
        total++;
        if (r !== exp[15:0]) $display("FAIL ignore_result: got %h, want %h", r, exp[15:0]);
        else passed++;
    endtask

    task automatic test_back_to_back();
        int first = -1, second = -1, pulses = 0;
        logic [15:0] r2 = 16'd0;
        logic [16:0] exp = model(3'd2, 8'hF3, 8'hA7);
        @(negedge i_clk);
        i_start = 1'b1; i_op = 3'd2; i_rd = 8'hF3; i_rr = 8'hA7;
        @(posedge i_clk);
        for (int k = 0; k <= 24; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) begin
                pulses++;
                if (first < 0) first = k;
                else begin second = k; r2 = {o_r1, o_r0}; end
            end
        end
        i_start = 1'b0;
        repeat (12) @(negedge i_clk);
        total++;
        if ({pulses, first, second} !== {32'd2, 32'd9, 32'd20})
            $display("FAIL b2b_timing: got pulses=%0d at %0d and %0d, want 2 at 9 and 20", pulses, first, second);
        else passed++;
        total++;
        if (r2 !== exp[15:0]) $display("FAIL b2b_result: got %h, want %h", r2, exp[15:0]);
        else passed++;
    endtask

    task automatic test_reset_abort();
        int pulses = 0, lat;
        logic [15:0] r;
        logic c, z, da, ba;
        run_op(3'd0, 8'hFF, 8'hFF, lat, r, c, z, da, ba);
        @(negedge i_clk);
        i_start = 1'b1; i_op = 3'd3; i_rd = 8'h55; i_rr = 8'h33;
        @(posedge i_clk);
        @(negedge i_clk);
        i_start = 1'b0;
        repeat (3) @(posedge i_clk);
        @(posedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        total++;
        if ({o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z} !== 21'd0)
            $display("FAIL abort_outputs: got busy=%b done=%b err=%b r=%h%h c=%b z=%b, want all zero",
                     o_busy, o_done, o_err, o_r1, o_r0, o_c, o_z);
        else passed++;
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge i_clk);
            if (o_done === 1'b1) pulses++;
        end
        total++;
        if (pulses !== 0) $display("FAIL abort_no_done: got %0d done pulses, want 0", pulses);
        else passed++;
        run_op(3'd3, 8'h01, 8'h01, lat, r, c, z, da, ba);
        total++;
        if ({lat == 9, r, c, z} !== {1'b1, 16'h0002, 1'b0, 1'b0})
            $display("FAIL abort_next_op: got lat=%0d r=%h c=%b z=%b, want lat=9 r=0002 c=0 z=0", lat, r, c, z);
        else passed++;
    endtask

    task automatic test_illegal();
        logic [17:0] held;
        for (int op = 6; op <= 7; op++) begin
            held = {o_r1, o_r0, o_c, o_z};
            @(negedge i_clk);
            i_start = 1'b1; i_op = 3'(op); i_rd = 8'h77; i_rr = 8'h99;
            @(posedge i_clk);
            #1;
            total++;
            if ({o_err, o_busy} !== 2'b10) $display("FAIL illegal_err[%0d]: got err=%b busy=%b, want err=1 busy=0", op, o_err, o_busy);
            else passed++;
            @(negedge i_clk);
            i_start = 1'b0;
            @(posedge i_clk);
            #1;
            total++;
            if ({o_err, o_busy, o_done} !== 3'b000) $display("FAIL illegal_clear[%0d]: got err=%b busy=%b done=%b, want 000", op, o_err, o_busy, o_done);
            else passed++;
            total++;
            if ({o_r1, o_r0, o_c, o_z} !== held) $display("FAIL illegal_hold[%0d]: got %h, want %h", op, {o_r1, o_r0, o_c, o_z}, held);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
        test_illegal();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fmul_seq_ctrl.md
FMUL_SEQ_CTRL -- requirements
Module: fmul_seq_ctrl

Interface
REQ-001 SHALL have no parameters; all widths are fixed.
REQ-002 i_clk  input  1  single clock; all state updates on the rising edge.
REQ-003 i_rst  input  1  reset; asynchronous, active-high.
REQ-004 i_start  input  1  request; sampled on the rising edge of i_clk.
REQ-005 i_op  input  3  0=MUL, 1=MULS, 2=MULSU, 3=FMUL, 4=FMULS, 5=FMULSU; 6 and 7 are illegal.
REQ-006 i_rd  input  8  multiplicand; signed for MULS, MULSU, FMULS and FMULSU.
REQ-007 i_rr  input  8  multiplier; signed for MULS and FMULS only.
REQ-008 o_busy  output  1  high while an operation is in progress.
REQ-009 o_done  output  1  one-cycle pulse when the result is valid.
REQ-010 o_r1  output  8  result high byte.
REQ-011 o_r0  output  8  result low byte.
REQ-012 o_c  output  1  carry flag.
REQ-013 o_z  output  1  zero flag.
REQ-014 o_err  output  1  one-cycle pulse when a start carries an illegal op.

Function
REQ-015 SHALL implement states IDLE, CALC, FIX and DONE; o_busy=1 in CALC, FIX and DONE.
REQ-016 Start acceptance: IDLE with i_start=1 and a legal i_op at edge E0 -> capture i_op, i_rd and i_rr, clear the accumulator, set count=0 and enter CALC.
REQ-017 CALC: one shift-add step per edge on the operand magnitudes; exactly 8 edges (E1..E8); count 7 at E8 -> FIX.
REQ-018 FIX (edge E9): apply the sign to form a 16-bit two's-complement product P; F ops set R=P<<1 (bit 0 = 0), other ops set R=P; o_c=P[15]; o_z=(R==0); register {o_r1,o_r0}=R; go to DONE.
REQ-019 DONE: o_done=1 for exactly the one cycle between E9 and E10; at E10 go to IDLE.
REQ-020 Latency: o_done rises 9 clocks after the accepting edge; back-to-back throughput is one operation per 11 clocks.
REQ-021 o_r1, o_r0, o_c and o_z SHALL hold their value from E9 until the next FIX or reset.
REQ-022 i_start while o_busy=1 SHALL be ignored; no queueing; captured operands are unaffected by input changes.
REQ-023 Illegal op (6 or 7) with i_start in IDLE: no acceptance; o_err=1 for one cycle after the edge; results unchanged; stay in IDLE.
REQ-024 Arithmetic: P SHALL equal the exact product of the operands interpreted per REQ-006/007, modulo 2^16.
REQ-025 The signed -128 operand (0x80) SHALL use magnitude 128 with no saturation; FMULS 0x80*0x80 gives R=0x8000.

Reset
REQ-026 i_rst=1 SHALL force immediately, independent of i_clk: state=IDLE, count=0, accumulator=0, o_busy=0, o_done=0, o_err=0, o_r1=0x00, o_r0=0x00, o_c=0, o_z=0.
REQ-027 Reset asserted in CALC or FIX SHALL abort the operation with no o_done pulse.
REQ-028 After deassertion, the first rising edge with i_start=1 and a legal op SHALL be accepted.

Verification
REQ-029 FMUL, rd=0x80, rr=0x80 -> o_done 9 clocks after acceptance; r1=0x80, r0=0x00, c=0, z=0.
REQ-030 FMUL, rd=0x80, rr=0x00 -> r1=0x00, r0=0x00, c=0, z=1; MUL, rd=0xFF, rr=0xFF -> 0xFE01, c=1, z=0.
REQ-031 MULS, rd=0x40, rr=0xC0 -> 0xF000, c=1; FMULSU, rd=0xC0, rr=0x40 -> 0xE000, c=1.
REQ-032 Start during CALC with different operands -> ignored; result matches the first request; exactly one o_done.
REQ-033 Reset at E4 of CALC -> all outputs 0 at once, no o_done; next FMUL, rd=0x01, rr=0x01 -> 0x0002, c=0, z=0.
REQ-034 i_op=6 with i_start in IDLE -> o_err pulse, o_busy stays 0, previous results held.
